// File: rtl/roach_clk_rst_sequencer.sv
`timescale 1ns/1ps
// roach_clk_rst_sequencer
//
// Power-up and recovery sequencer for the board clock infrastructure.
// It waits for the MMCM to lock and stay locked, pulses the IDELAYCTRL
// reset, waits for IDELAY calibration, and then releases the user-logic
// reset. Loss of lock or loss of IDELAY ready re-runs the sequence.
// Repeated ready timeouts park the block in FAULT until software asks
// for a retry.
//
// Ports
//   sys_clk        in   single clock for all logic
//   sys_rst_n      in   asynchronous active-low reset
//   sys_clk_lock   in   MMCM lock (asynchronous, synchronized here)
//   idelay_rdy     in   IDELAYCTRL ready (asynchronous, synchronized here)
//   retry_req      in   single-cycle pulse that leaves FAULT
//   idelay_rst     out  IDELAYCTRL reset, active high
//   user_rst       out  user-logic reset, active high
//   ready          out  high only in RUN
//   fault          out  high only in FAULT
//   state          out  current state encoding
//   lock_loss_cnt  out  saturating count of lock drops seen in RUN
//   retry_cnt      out  consecutive ready timeouts
//
// state         | meaning
// --------------+-------------------------------------------------------
// 0 WAIT_LOCK   | hold everything in reset until the MMCM reports lock
// 1 SETTLE      | lock must stay high for SETTLE_CYCLES
// 2 IDLY_RST    | IDELAYCTRL reset pulse of IDELAY_RST_CYCLES
// 3 WAIT_RDY    | wait up to RDY_TIMEOUT cycles for IDELAY calibration
// 4 RUN         | user logic released
// 5 FAULT       | too many ready timeouts; wait for retry_req

module roach_clk_rst_sequencer #(
    parameter int SETTLE_CYCLES     = 1024,
    parameter int IDELAY_RST_CYCLES = 64,
    parameter int RDY_TIMEOUT       = 4096,
    parameter int RETRY_MAX         = 3
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       sys_clk_lock,
    input  logic       idelay_rdy,
    input  logic       retry_req,
    output logic       idelay_rst,
    output logic       user_rst,
    output logic       ready,
    output logic       fault,
    output logic [2:0] state,
    output logic [7:0] lock_loss_cnt,
    output logic [3:0] retry_cnt
);

    localparam logic [2:0] ST_WAIT_LOCK = 3'd0;
    localparam logic [2:0] ST_SETTLE    = 3'd1;
    localparam logic [2:0] ST_IDLY_RST  = 3'd2;
    localparam logic [2:0] ST_WAIT_RDY  = 3'd3;
    localparam logic [2:0] ST_RUN       = 3'd4;
    localparam logic [2:0] ST_FAULT     = 3'd5;

    localparam int P_MAX_A = (SETTLE_CYCLES > IDELAY_RST_CYCLES) ? SETTLE_CYCLES : IDELAY_RST_CYCLES;
    localparam int P_MAX   = (P_MAX_A > RDY_TIMEOUT) ? P_MAX_A : RDY_TIMEOUT;
    localparam int CNT_W   = (P_MAX > 2) ? $clog2(P_MAX) : 1;

    // Load values are one less than the phase length: the phase ends on
    // the cycle the counter is already at zero.
    localparam logic [CNT_W-1:0] C_SETTLE = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_IRST   = CNT_W'(IDELAY_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_RDY    = CNT_W'(RDY_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] C_ONE    = CNT_W'(1);
    localparam logic [3:0]       C_RMAX   = 4'(RETRY_MAX);

    logic             r_lock_meta;
    logic             r_lock_s;
    logic             r_rdy_meta;
    logic             r_rdy_s;

    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_retry_cnt;
    logic [7:0]       r_lock_loss_cnt;
    logic             r_idelay_rst;
    logic             r_user_rst;
    logic             r_ready;
    logic             r_fault;

    logic [2:0]       w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [3:0]       w_retry_nxt;
    logic [3:0]       w_retry_inc;
    logic [7:0]       w_llc_nxt;
    logic             w_cnt_zero;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_lock_meta <= 1'b0;
            r_lock_s    <= 1'b0;
            r_rdy_meta  <= 1'b0;
            r_rdy_s     <= 1'b0;
        end else begin
            r_lock_meta <= sys_clk_lock;
            r_lock_s    <= r_lock_meta;
            r_rdy_meta  <= idelay_rdy;
            r_rdy_s     <= r_rdy_meta;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_retry_nxt = r_retry_cnt;
        w_retry_inc = r_retry_cnt + 4'd1;
        w_llc_nxt   = r_lock_loss_cnt;
        w_cnt_zero  = (r_cnt == '0);

        case (r_state)
            ST_WAIT_LOCK: begin
                if (r_lock_s) begin
                    w_state_nxt = ST_SETTLE;
                    w_cnt_nxt   = C_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (!r_lock_s) begin
                    w_state_nxt = ST_WAIT_LOCK;
                end else if (w_cnt_zero) begin
                    w_state_nxt = ST_IDLY_RST;
                    w_cnt_nxt   = C_IRST;
                end else begin
                    w_cnt_nxt = r_cnt - C_ONE;
                end
            end
            ST_IDLY_RST: begin
                if (!r_lock_s) begin
                    w_state_nxt = ST_WAIT_LOCK;
                end else if (w_cnt_zero) begin
                    w_state_nxt = ST_WAIT_RDY;
                    w_cnt_nxt   = C_RDY;
                end else begin
                    w_cnt_nxt = r_cnt - C_ONE;
                end
            end
            ST_WAIT_RDY: begin
                // ready is tested before the timeout so it wins a tie
                if (!r_lock_s) begin
                    w_state_nxt = ST_WAIT_LOCK;
                end else if (r_rdy_s) begin
                    w_state_nxt = ST_RUN;
                    w_retry_nxt = 4'd0;
                end else if (w_cnt_zero) begin
                    w_retry_nxt = w_retry_inc;
                    if (w_retry_inc == C_RMAX) begin
                        w_state_nxt = ST_FAULT;
                    end else begin
                        w_state_nxt = ST_IDLY_RST;
                        w_cnt_nxt   = C_IRST;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - C_ONE;
                end
            end
            ST_RUN: begin
                if (!r_lock_s) begin
                    w_state_nxt = ST_WAIT_LOCK;
                    if (r_lock_loss_cnt != 8'hFF) begin
                        w_llc_nxt = r_lock_loss_cnt + 8'd1;
                    end
                end else if (!r_rdy_s) begin
                    w_state_nxt = ST_IDLY_RST;
                    w_cnt_nxt   = C_IRST;
                end
            end
            ST_FAULT: begin
                if (retry_req) begin
                    w_state_nxt = ST_WAIT_LOCK;
                    w_retry_nxt = 4'd0;
                end
            end
            default: begin
                w_state_nxt = ST_WAIT_LOCK;
            end
        endcase
    end

    // Outputs are decoded from the next state so they update on the same
    // edge as the state register.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state         <= ST_WAIT_LOCK;
            r_cnt           <= '0;
            r_retry_cnt     <= 4'd0;
            r_lock_loss_cnt <= 8'd0;
            r_idelay_rst    <= 1'b1;
            r_user_rst      <= 1'b1;
            r_ready         <= 1'b0;
            r_fault         <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_cnt           <= w_cnt_nxt;
            r_retry_cnt     <= w_retry_nxt;
            r_lock_loss_cnt <= w_llc_nxt;
            r_idelay_rst    <= (w_state_nxt == ST_WAIT_LOCK) ||
                               (w_state_nxt == ST_SETTLE)    ||
                               (w_state_nxt == ST_IDLY_RST);
            r_user_rst      <= (w_state_nxt != ST_RUN);
            r_ready         <= (w_state_nxt == ST_RUN);
            r_fault         <= (w_state_nxt == ST_FAULT);
        end
    end

    assign idelay_rst    = r_idelay_rst;
    assign user_rst      = r_user_rst;
    assign ready         = r_ready;
    assign fault         = r_fault;
    assign state         = r_state;
    assign lock_loss_cnt = r_lock_loss_cnt;
    assign retry_cnt     = r_retry_cnt;

endmodule
